control_vec_secuenciador: RTL

- Parametrised, pipelined successor to the combinational vector-processor control unit.
- Decodes 4-bit opcodes into the same control fields, then registers them through decode, EXE, MEM and WB stages.
- Sequences vector ops over VLEN elements in LANES-wide beats, with a valid/ready issue handshake and a global stall.

---
 rtl/ctrl_vec_pkg.sv | 101 ++++++++++
 rtl/ctrl_vec_decoder.sv | 26 ++
 rtl/control_vec_secuenciador.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_vec_pkg.sv
// Shared types for the pipelined vector control sequencer: opcode constants,
// the 14-field control word, per-stage control slices, FSM states and the
// opcode decode function.
package ctrl_vec_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_0001 = 4'h1;
    localparam logic [3:0] OP_0010 = 4'h2;
    localparam logic [3:0] OP_0011 = 4'h3;
    localparam logic [3:0] OP_0100 = 4'h4;
    localparam logic [3:0] OP_0101 = 4'h5;
    localparam logic [3:0] OP_0110 = 4'h6;
    localparam logic [3:0] OP_0111 = 4'h7;
    localparam logic [3:0] OP_1000 = 4'h8;
    localparam logic [3:0] OP_1001 = 4'h9;
    localparam logic [3:0] OP_1010 = 4'hA;
    localparam logic [3:0] OP_1011 = 4'hB;
    localparam logic [3:0] OP_1100 = 4'hC;
    localparam logic [3:0] OP_1101 = 4'hD;
    localparam logic [3:0] OP_1110 = 4'hE;
    localparam logic [3:0] OP_1111 = 4'hF;

    // Field order matches the decode table, MSB first.
    typedef struct packed {
        logic reg_rdv;
        logic reg_rds;
        logic sel_dest;
        logic sel_op;
        logic sel_ad;
        logic sel_int;
        logic sum_mem;
        logic sel_mem;
        logic sel_data;
        logic mem_wr;
        logic sel_wb;
        logic reg_wrv;
        logic reg_wrs;
        logic sel_pc;
    } ctrl_word_t;

    typedef struct packed {
        logic sel_op;
        logic sel_ad;
        logic sel_int;
    } ex_ctl_t;

    typedef struct packed {
        logic sum_mem;
        logic sel_mem;
        logic sel_data;
        logic mem_wr;
    } mem_ctl_t;

    typedef struct packed {
        logic sel_wb;
        logic reg_wrv;
        logic reg_wrs;
    } wb_ctl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SEQ   = 2'd2
    } seq_state_t;

    localparam ctrl_word_t CW_NOP   = 14'b0;
    // Reset / undecodable row: only the PC select is asserted.
    localparam ctrl_word_t CW_RESET = 14'b00000000000001;

    function automatic ctrl_word_t decode_op(input logic [3:0] op);
        ctrl_word_t cw;
        case (op)
            OP_NOP:                            cw = 14'b00000000000000;
            OP_0001, OP_0010:                  cw = 14'b10000000001100;
            OP_0011:                           cw = 14'b10100001100100;
            OP_0100:                           cw = 14'b10100001110000;
            OP_0101, OP_1010, OP_1011:         cw = 14'b11000100001000;
            OP_0110, OP_0111, OP_1000, OP_1001: cw = 14'b11010100001000;
            OP_1100:                           cw = 14'b00100000001010;
            OP_1101:                           cw = 14'b01001000001010;
            OP_1110:                           cw = 14'b10100000100100;
            OP_1111:                           cw = 14'b10100011100001;
            default:                           cw = CW_RESET;
        endcase
        return cw;
    endfunction

    function automatic ex_ctl_t ex_slice(input ctrl_word_t cw);
        return '{sel_op: cw.sel_op, sel_ad: cw.sel_ad, sel_int: cw.sel_int};
    endfunction

    function automatic mem_ctl_t mem_slice(input ctrl_word_t cw);
        return '{sum_mem: cw.sum_mem, sel_mem: cw.sel_mem,
                 sel_data: cw.sel_data, mem_wr: cw.mem_wr};
    endfunction

    function automatic wb_ctl_t wb_slice(input ctrl_word_t cw);
        return '{sel_wb: cw.sel_wb, reg_wrv: cw.reg_wrv, reg_wrs: cw.reg_wrs};
    endfunction

endpackage

// File: rtl/ctrl_vec_decoder.sv
// Combinational opcode-to-control-word lookup. Opcodes with any bit set
// above bit 3 take the default (PC-select only) row.
module ctrl_vec_decoder
    import ctrl_vec_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] i_opcode,
    output ctrl_word_t       o_cw,
    output logic             o_vector
);

    logic [31:0] w_ext;

    // Zero-extend so the upper-bit test works for any opcode width.
    always_comb begin
        w_ext = 32'(i_opcode);
        if (w_ext[31:4] == 28'd0) begin
            o_cw = decode_op(w_ext[3:0]);
        end else begin
            o_cw = CW_RESET;
        end
        o_vector = o_cw.reg_rdv | o_cw.reg_wrv;
    end

endmodule

// File: rtl/control_vec_secuenciador.sv
// Pipelined vector control sequencer: decodes an opcode, expands vector ops
// into VLEN/LANES beats and carries the controls through DEC, EXE, MEM, WB.
// Optional macro CTRL_VEC_PERF_CNT_EN adds perf_instr / perf_stall counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | out of reset, nothing accepted yet; decode holds reset word
// ST_ISSUE | ready for a new opcode; no accept inserts an all-zero bubble
// ST_SEQ   | issuing remaining beats of a multi-beat vector op
module control_vec_secuenciador
    import ctrl_vec_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int VLEN   = 8,
    parameter int LANES  = 4,
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode_in,
    input  logic              stall,
    output logic              dec_valid,
    output logic              dec_sel_pc,
    output logic              dec_reg_rdv,
    output logic              dec_reg_rds,
    output logic              dec_sel_dest,
    output logic              ex_valid,
    output logic              ex_sel_op,
    output logic              ex_sel_ad,
    output logic              ex_sel_int,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [BEAT_W-1:0] ex_beat,
    output logic              mem_valid,
    output logic              mem_sum_mem,
    output logic              mem_sel_mem,
    output logic              mem_sel_data,
    output logic              mem_mem_wr,
    output logic              wb_valid,
    output logic              wb_sel_wb,
    output logic              wb_reg_wrv,
    output logic              wb_reg_wrs
`ifdef CTRL_VEC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_instr,
    output logic [31:0]       perf_stall
`endif
);

    localparam int                NB        = VLEN / LANES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);
    localparam logic              MULTI     = (NB > 1);

    ctrl_word_t        w_cw;
    logic              w_vector;
    logic              w_redirect;
    logic              w_in_ready;
    logic              w_accept;

    seq_state_t        r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt;
    ctrl_word_t        r_held_cw;
    logic [OPC_W-1:0]  r_held_opc;

    logic              r_dec_valid, w_dec_valid_nxt;
    ctrl_word_t        r_dec_cw, w_dec_cw_nxt;
    logic [OPC_W-1:0]  r_dec_opc, w_dec_opc_nxt;
    logic [BEAT_W-1:0] r_dec_beat, w_dec_beat_nxt;

    logic              r_ex_valid;
    ex_ctl_t           r_ex_ctl;
    mem_ctl_t          r_ex_mem;
    wb_ctl_t           r_ex_wb;
    logic [OPC_W-1:0]  r_ex_opc;
    logic [BEAT_W-1:0] r_ex_beat;

    logic              r_mem_valid;
    mem_ctl_t          r_mem_ctl;
    wb_ctl_t           r_mem_wb;

    logic              r_wb_valid;
    wb_ctl_t           r_wb_ctl;

    ctrl_vec_decoder #(.OPC_W(OPC_W)) u_decoder (
        .i_opcode (opcode_in),
        .o_cw     (w_cw),
        .o_vector (w_vector)
    );

    // A branch-type op (1111) in EXE flushes decode on the next free edge.
    assign w_redirect = r_ex_valid && (r_ex_opc == OPC_W'(OP_1111)) && !stall;

    // Next-state, handshake and next decode-stage contents.
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        w_dec_valid_nxt = r_dec_valid;
        w_dec_cw_nxt    = r_dec_cw;
        w_dec_opc_nxt   = r_dec_opc;
        w_dec_beat_nxt  = r_dec_beat;
        w_in_ready      = !stall && !w_redirect && (r_state != ST_SEQ);
        w_accept        = in_valid && w_in_ready;
        if (!stall) begin
            if (w_redirect) begin
                w_dec_valid_nxt = 1'b0;
                w_dec_cw_nxt    = CW_NOP;
                w_dec_opc_nxt   = '0;
                w_dec_beat_nxt  = '0;
                w_beat_nxt      = '0;
                if (r_state == ST_SEQ) begin
                    w_state_nxt = ST_ISSUE;
                end
            end else if (r_state == ST_SEQ) begin
                w_dec_valid_nxt = 1'b1;
                w_dec_cw_nxt    = r_held_cw;
                w_dec_opc_nxt   = r_held_opc;
                w_dec_beat_nxt  = r_beat;
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = ST_ISSUE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt  = r_beat + BEAT_W'(1);
                end
            end else if (w_accept) begin
                w_dec_valid_nxt = 1'b1;
                w_dec_cw_nxt    = w_cw;
                w_dec_opc_nxt   = opcode_in;
                w_dec_beat_nxt  = '0;
                if (w_vector && MULTI) begin
                    w_state_nxt = ST_SEQ;
                    w_beat_nxt  = BEAT_W'(1);
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end else if (r_state == ST_IDLE) begin
                w_dec_valid_nxt = 1'b0;
                w_dec_cw_nxt    = CW_RESET;
                w_dec_opc_nxt   = '0;
                w_dec_beat_nxt  = '0;
            end else begin
                w_dec_valid_nxt = 1'b0;
                w_dec_cw_nxt    = CW_NOP;
                w_dec_opc_nxt   = '0;
                w_dec_beat_nxt  = '0;
            end
        end
    end

    // FSM state, beat counter and the control word held across beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_beat     <= '0;
            r_held_cw  <= CW_NOP;
            r_held_opc <= '0;
        end else if (!stall) begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_held_cw  <= w_cw;
                r_held_opc <= opcode_in;
            end
        end
    end

    // Stage registers: everything advances one stage per unstalled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dec_valid <= 1'b0;
            r_dec_cw    <= CW_RESET;
            r_dec_opc   <= '0;
            r_dec_beat  <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_ctl    <= '0;
            r_ex_mem    <= '0;
            r_ex_wb     <= '0;
            r_ex_opc    <= '0;
            r_ex_beat   <= '0;
            r_mem_valid <= 1'b0;
            r_mem_ctl   <= '0;
            r_mem_wb    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_ctl    <= '0;
        end else if (!stall) begin
            r_dec_valid <= w_dec_valid_nxt;
            r_dec_cw    <= w_dec_cw_nxt;
            r_dec_opc   <= w_dec_opc_nxt;
            r_dec_beat  <= w_dec_beat_nxt;
            r_ex_valid  <= r_dec_valid;
            r_ex_ctl    <= ex_slice(r_dec_cw);
            r_ex_mem    <= mem_slice(r_dec_cw);
            r_ex_wb     <= wb_slice(r_dec_cw);
            r_ex_opc    <= r_dec_opc;
            r_ex_beat   <= r_dec_beat;
            r_mem_valid <= r_ex_valid;
            r_mem_ctl   <= r_ex_mem;
            r_mem_wb    <= r_ex_wb;
            r_wb_valid  <= r_mem_valid;
            r_wb_ctl    <= r_mem_wb;
        end
    end

`ifdef CTRL_VEC_PERF_CNT_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_stall;

    // Free-running wrap-around counters of accepts and stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_instr <= r_perf_instr + 32'd1;
            end
            if (stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_instr = r_perf_instr;
    assign perf_stall = r_perf_stall;
`endif

    assign in_ready     = w_in_ready;
    assign dec_valid    = r_dec_valid;
    assign dec_sel_pc   = r_dec_cw.sel_pc;
    assign dec_reg_rdv  = r_dec_cw.reg_rdv;
    assign dec_reg_rds  = r_dec_cw.reg_rds;
    assign dec_sel_dest = r_dec_cw.sel_dest;
    assign ex_valid     = r_ex_valid;
    assign ex_sel_op    = r_ex_ctl.sel_op;
    assign ex_sel_ad    = r_ex_ctl.sel_ad;
    assign ex_sel_int   = r_ex_ctl.sel_int;
    assign ex_opcode    = r_ex_opc;
    assign ex_beat      = r_ex_beat;
    assign mem_valid    = r_mem_valid;
    assign mem_sum_mem  = r_mem_ctl.sum_mem;
    assign mem_sel_mem  = r_mem_ctl.sel_mem;
    assign mem_sel_data = r_mem_ctl.sel_data;
    assign mem_mem_wr   = r_mem_ctl.mem_wr;
    assign wb_valid     = r_wb_valid;
    assign wb_sel_wb    = r_wb_ctl.sel_wb;
    assign wb_reg_wrv   = r_wb_ctl.reg_wrv;
    assign wb_reg_wrs   = r_wb_ctl.reg_wrs;

endmodule
